// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter sharing one resource between N requesters.
// The search for a new owner starts at a rotating pointer and runs downward
// with wrap. The owner keeps the grant until it raises done, drops its
// request, or has held the grant for MAX_HOLD cycles (MAX_HOLD=0 disables the
// hold limit). On release the next winner is granted on the following edge,
// so there is no dead cycle between owners.
//
// Ports:
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   req[N]     request vector, bit i = requester i wants the resource
//   done       current owner releases the grant (ignored while idle)
//   gnt[N]     registered one-hot grant
//   gnt_id     binary index of the owner, 0 when idle
//   gnt_valid  high while a grant is active (OR of gnt)
//   timeout    one-cycle pulse after a grant is revoked by the hold limit
//
// state | meaning
// IDLE  | no owner, outputs zero
// GRANT | requester gnt_id owns the resource
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic           timeout_q, timeout_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           owner_req;
  logic           hold_hit;
  logic           release_now;

  // Priority search: ptr, ptr-1, ..., 0, N-1, ..., ptr+1. Because ptr is
  // left at owner-1 after every grant, the previous owner is searched last.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_v;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    idx_v     = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) - i;
      if (idx < 0) idx = idx + N;
      idx_v = IDW'(idx);
      if (!win_found && req[idx_v]) begin
        win_found = 1'b1;
        win_id    = idx_v;
      end
    end
  end

  assign owner_req   = req[gnt_id_q];
  assign hold_hit    = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
  assign release_now = done || !owner_req || hold_hit;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    if (state_q == IDLE || release_now) begin
      // done or a dropped request take precedence over the hold limit
      timeout_d = (state_q == GRANT) && hold_hit && !done && owner_req;
      if (win_found) begin
        state_d  = GRANT;
        gnt_d    = {{(N-1){1'b0}}, 1'b1} << win_id;
        gnt_id_d = win_id;
        ptr_d    = (win_id == '0) ? IDW'(N - 1) : win_id - 1'b1;
        hold_d   = CW'(1);
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        hold_d   = '0;
      end
    end else if (hold_q != {CW{1'b1}}) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= IDW'(N - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (N=4, MAX_HOLD=8). Inputs change on falling edges;
// each step queues the outputs expected after the next rising edge, and a
// monitor pops and compares them shortly after that edge.
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter #(.N(4), .IDW(2), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       to;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Drive inputs now, queue expected outputs after the next rising edge,
  // then advance to the following falling edge.
  task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                      input logic [1:0] eid, input logic eto, input string name);
    exp_t e;
    req  = r;
    done = d;
    e.gnt  = eg;
    e.id   = eid;
    e.to   = eto;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, " gnt"},       32'(gnt),       32'(mon_e.gnt));
      check({mon_e.name, " gnt_id"},    32'(gnt_id),    32'(mon_e.id));
      check({mon_e.name, " gnt_valid"}, 32'(gnt_valid), 32'(|mon_e.gnt));
      check({mon_e.name, " timeout"},   32'(timeout),   32'(mon_e.to));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;

    step(4'b1111, 0, 4'b0000, 2'd0, 0, "rst0");
    step(4'b1111, 0, 4'b0000, 2'd0, 0, "rst1");
    rst_n = 1'b1;
    step(4'b1111, 0, 4'b1000, 2'd3, 0, "rst_release");

    // walk the pointer back to 3 (granting 0 leaves ptr=3)
    step(4'b0000, 0, 4'b0000, 2'd0, 0, "drop_all");
    step(4'b0001, 0, 4'b0001, 2'd0, 0, "grant0");
    step(4'b0000, 0, 4'b0000, 2'd0, 0, "idle");

    step(4'b1010, 0, 4'b1000, 2'd3, 0, "prio_1010");
    step(4'b1010, 1, 4'b0010, 2'd1, 0, "handoff_done");
    step(4'b1010, 0, 4'b0010, 2'd1, 0, "hold1");

    // rotation with done every granted cycle
    step(4'b1111, 1, 4'b0001, 2'd0, 0, "rot_a");
    step(4'b1111, 1, 4'b1000, 2'd3, 0, "rot_3");
    step(4'b1111, 1, 4'b0100, 2'd2, 0, "rot_2");
    step(4'b1111, 1, 4'b0010, 2'd1, 0, "rot_1");
    step(4'b1111, 1, 4'b0001, 2'd0, 0, "rot_0");
    step(4'b1111, 1, 4'b1000, 2'd3, 0, "rot_3b");
    step(4'b1111, 1, 4'b0100, 2'd2, 0, "rot_2b");

    // request drop
    step(4'b0110, 0, 4'b0100, 2'd2, 0, "own2_hold");
    step(4'b0010, 0, 4'b0010, 2'd1, 0, "drop_req2");
    step(4'b0100, 1, 4'b0100, 2'd2, 0, "own2_again");
    step(4'b0000, 0, 4'b0000, 2'd0, 0, "drop_to_idle");

    // hold limit with a competing requester
    step(4'b1000, 0, 4'b1000, 2'd3, 0, "grant3");
    step(4'b0101, 0, 4'b0100, 2'd2, 0, "to_hold1");
    for (int i = 0; i < 7; i++) step(4'b0101, 0, 4'b0100, 2'd2, 0, "to_hold");
    step(4'b0101, 0, 4'b0001, 2'd0, 1, "to_handoff");

    // sole requester: re-granted, timeout every 8 cycles
    step(4'b0100, 0, 4'b0100, 2'd2, 0, "sole_start");
    for (int i = 0; i < 7; i++) step(4'b0100, 0, 4'b0100, 2'd2, 0, "sole_hold");
    step(4'b0100, 0, 4'b0100, 2'd2, 1, "sole_to1");
    for (int i = 0; i < 7; i++) step(4'b0100, 0, 4'b0100, 2'd2, 0, "sole_hold2");
    step(4'b0100, 0, 4'b0100, 2'd2, 1, "sole_to2");

    // done at the hold limit wins over timeout
    for (int i = 0; i < 7; i++) step(4'b0100, 0, 4'b0100, 2'd2, 0, "sole_hold3");
    step(4'b0100, 1, 4'b0100, 2'd2, 0, "done_at_limit");

    // async reset mid-grant
    step(4'b0001, 0, 4'b0001, 2'd0, 0, "own0");
    #2;
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    check("async gnt",       32'(gnt),       32'h0);
    check("async gnt_id",    32'(gnt_id),    32'h0);
    check("async gnt_valid", 32'(gnt_valid), 32'h0);
    check("async timeout",   32'(timeout),   32'h0);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 0, 4'b1000, 2'd3, 0, "after_async");
    step(4'b1111, 0, 4'b1000, 2'd3, 0, "after_async_hold");

    check("queue drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
